// File: rtl/ram_master_pkg.sv
// Shared types for the ram_master initiator: FSM state encoding and its width.
// Optional build macro used by ram_master: RAM_MASTER_BOUNDS_CHK_EN.
package ram_master_pkg;

  // Width of the FSM state register, independent of the RAM geometry.
  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_ADDR = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/ram_master_addr_seq.sv
// ram_addr_seq: loadable RAM address register with MEMORY_SIZE wrap and the
// burst remaining-word down-counter. `last` flags the final word of a burst.
module ram_addr_seq #(
  parameter int ADDR_SIZE   = 4,
  parameter int MEMORY_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ADDR_SIZE-1:0] load_addr,
  input  logic [ADDR_SIZE-1:0] load_len,
  input  logic                 advance,
  output logic [ADDR_SIZE-1:0] addr,
  output logic                 last
);

  // Last valid RAM index; reaching it wraps the address back to zero.
  localparam logic [ADDR_SIZE-1:0] WRAP_ADDR = ADDR_SIZE'(MEMORY_SIZE - 1);

  logic [ADDR_SIZE-1:0] addr_reg;
  logic [ADDR_SIZE-1:0] remain_reg;

  // Load on request accept, step address and count once per delivered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg   <= '0;
      remain_reg <= '0;
    end else if (load) begin
      addr_reg   <= load_addr;
      remain_reg <= load_len;
    end else if (advance) begin
      addr_reg   <= (addr_reg == WRAP_ADDR) ? '0 : addr_reg + ADDR_SIZE'(1);
      remain_reg <= remain_reg - ADDR_SIZE'(1);
    end
  end

  assign addr = addr_reg;
  assign last = (remain_reg == '0);

endmodule

// File: rtl/ram_master.sv
// ram_master: client-facing initiator for the single-port async-read ram.
// Single-word writes and burst reads, one request in flight at a time.
// Optional macro RAM_MASTER_BOUNDS_CHK_EN: reject start addresses that are
// outside the RAM with a one-cycle err pulse instead of executing them.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_SIZE   = 4,
  parameter int WORD_SIZE   = 8,
  parameter int MEMORY_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_len,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_last,
  output logic                 err,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_data_in,
  input  logic [WORD_SIZE-1:0] ram_data_out,
  output logic                 ram_wr,
  output logic                 ram_cs
);

  state_t               state_reg;
  logic [WORD_SIZE-1:0] wdata_reg;
  logic [WORD_SIZE-1:0] rsp_data_reg;
  logic                 rsp_valid_reg;
  logic                 rsp_last_reg;
  logic                 err_reg;

  logic                 req_fire;
  logic                 addr_ok;
  logic                 seq_load;
  logic                 seq_advance;
  logic [ADDR_SIZE-1:0] seq_addr;
  logic                 seq_last;

  assign req_ready = (state_reg == IDLE) && !rst;
  assign req_fire  = req_valid && req_ready;

`ifdef RAM_MASTER_BOUNDS_CHK_EN
  // Start address must fall inside the RAM for the request to execute.
  assign addr_ok = (int'(req_addr) < MEMORY_SIZE);
`else
  assign addr_ok = 1'b1;
`endif

  // Address only moves to the next word once the current one was taken.
  assign seq_load    = req_fire && addr_ok;
  assign seq_advance = (state_reg == RESP) && rsp_ready && !seq_last;

  ram_addr_seq #(
    .ADDR_SIZE   (ADDR_SIZE),
    .MEMORY_SIZE (MEMORY_SIZE)
  ) u_addr_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (seq_load),
    .load_addr (req_addr),
    .load_len  (req_len),
    .advance   (seq_advance),
    .addr      (seq_addr),
    .last      (seq_last)
  );

  // Request/response FSM with registered response and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wdata_reg     <= '0;
      rsp_data_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_last_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_fire) begin
            wdata_reg <= req_wdata;
            if (!addr_ok) begin
              err_reg <= 1'b1;
            end else if (req_wr) begin
              state_reg <= WRITE;
            end else begin
              state_reg <= RD_ADDR;
            end
          end
        end
        WRITE: begin
          state_reg <= IDLE;
        end
        RD_ADDR: begin
          // Async RAM read settles within the cycle; capture it here so the
          // response stays stable however long the client stalls.
          rsp_data_reg  <= ram_data_out;
          rsp_valid_reg <= 1'b1;
          rsp_last_reg  <= seq_last;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_last_reg  <= 1'b0;
            state_reg     <= seq_last ? IDLE : RD_ADDR;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_last    = rsp_last_reg;
  assign err         = err_reg;

  // RAM pins come only from registered state, address and data.
  assign ram_cs      = (state_reg == WRITE) || (state_reg == RD_ADDR);
  assign ram_wr      = (state_reg == WRITE);
  assign ram_addr    = seq_addr;
  assign ram_data_in = wdata_reg;

endmodule
